// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control field widths, memory width and ALU op
// encodings, and the grouped execute-stage control struct.
package pipeline_pkg;

  localparam int ALU_OP_W    = 3;
  localparam int MEM_WIDTH_W = 2;

  localparam logic [MEM_WIDTH_W-1:0] MEM_BYTE = 2'b00;
  localparam logic [MEM_WIDTH_W-1:0] MEM_HALF = 2'b01;
  localparam logic [MEM_WIDTH_W-1:0] MEM_WORD = 2'b11;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_LUI = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_RTY = 3'b111;

  typedef struct packed {
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
    logic                   mem_to_reg;
    logic                   alu_src;
    logic                   reg_dst;
    logic                   mem_signed;
    logic [ALU_OP_W-1:0]    alu_op;
    logic [MEM_WIDTH_W-1:0] mem_width;
  } ex_ctrl_t;

  // An invalid slot must never carry side effects, so its control collapses to zero.
  function automatic ex_ctrl_t gate_ctrl(input ex_ctrl_t ctrl, input logic valid);
    return valid ? ctrl : '0;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async reset, enable (hold) and synchronous clear (bubble).
module pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold has priority over clear, so a clear raised while held is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (enable) begin
      if (clear) q <= '0;
      else       q <= d;
    end
  end

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register. Define ID_EX_TRACE_EN to add pc/instr trace fields
// and a saturating bubble counter.
module id_ex_register
  import pipeline_pkg::*;
#(
  parameter int DATA_SIZE     = 32,
  parameter int REG_ADDR_SIZE = 5,
  parameter int ALU_OP_SIZE   = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_halt,
  input  logic                     i_flush,
  input  logic                     i_valid,
  input  logic [DATA_SIZE-1:0]     i_rs_data,
  input  logic [DATA_SIZE-1:0]     i_rt_data,
  input  logic [DATA_SIZE-1:0]     i_imm_ext,
  input  logic [REG_ADDR_SIZE-1:0] i_rs_addr,
  input  logic [REG_ADDR_SIZE-1:0] i_rt_addr,
  input  logic [REG_ADDR_SIZE-1:0] i_rd_addr,
  input  logic [4:0]               i_shamt,
  input  logic                     i_reg_write,
  input  logic                     i_mem_read,
  input  logic                     i_mem_write,
  input  logic                     i_mem_to_reg,
  input  logic                     i_alu_src,
  input  logic                     i_reg_dst,
  input  logic                     i_mem_signed,
  input  logic [ALU_OP_SIZE-1:0]   i_alu_op,
  input  logic [1:0]               i_mem_width,
`ifdef ID_EX_TRACE_EN
  input  logic [DATA_SIZE-1:0]     i_pc_plus4,
  input  logic [DATA_SIZE-1:0]     i_instr,
  output logic [DATA_SIZE-1:0]     o_pc_plus4,
  output logic [DATA_SIZE-1:0]     o_instr,
  output logic [15:0]              o_bubble_count,
`endif
  output logic [DATA_SIZE-1:0]     o_rs_data,
  output logic [DATA_SIZE-1:0]     o_rt_data,
  output logic [DATA_SIZE-1:0]     o_imm_ext,
  output logic [REG_ADDR_SIZE-1:0] o_rs_addr,
  output logic [REG_ADDR_SIZE-1:0] o_rt_addr,
  output logic [REG_ADDR_SIZE-1:0] o_rd_addr,
  output logic [4:0]               o_shamt,
  output logic                     o_reg_write,
  output logic                     o_mem_read,
  output logic                     o_mem_write,
  output logic                     o_mem_to_reg,
  output logic                     o_alu_src,
  output logic                     o_reg_dst,
  output logic                     o_mem_signed,
  output logic [ALU_OP_SIZE-1:0]   o_alu_op,
  output logic [1:0]               o_mem_width,
  output logic                     o_valid
);

`ifdef ID_EX_TRACE_EN
  localparam int DATA_W = 5 * DATA_SIZE + 3 * REG_ADDR_SIZE + 5 + 1;
`else
  localparam int DATA_W = 3 * DATA_SIZE + 3 * REG_ADDR_SIZE + 5 + 1;
`endif

  ex_ctrl_t          ctrl_raw;
  ex_ctrl_t          ctrl_d;
  ex_ctrl_t          ctrl_q;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;
  logic              load_en;

  assign load_en = ~i_halt;

  assign ctrl_raw = '{reg_write:  i_reg_write,
                      mem_read:   i_mem_read,
                      mem_write:  i_mem_write,
                      mem_to_reg: i_mem_to_reg,
                      alu_src:    i_alu_src,
                      reg_dst:    i_reg_dst,
                      mem_signed: i_mem_signed,
                      alu_op:     i_alu_op,
                      mem_width:  i_mem_width};
  assign ctrl_d = gate_ctrl(ctrl_raw, i_valid);

`ifdef ID_EX_TRACE_EN
  assign data_d = {i_pc_plus4, i_instr, i_rs_data, i_rt_data, i_imm_ext,
                   i_rs_addr, i_rt_addr, i_rd_addr, i_shamt, i_valid};
  assign {o_pc_plus4, o_instr, o_rs_data, o_rt_data, o_imm_ext,
          o_rs_addr, o_rt_addr, o_rd_addr, o_shamt, o_valid} = data_q;
`else
  assign data_d = {i_rs_data, i_rt_data, i_imm_ext,
                   i_rs_addr, i_rt_addr, i_rd_addr, i_shamt, i_valid};
  assign {o_rs_data, o_rt_data, o_imm_ext,
          o_rs_addr, o_rt_addr, o_rd_addr, o_shamt, o_valid} = data_q;
`endif

  pipe_reg #(.WIDTH($bits(ex_ctrl_t))) u_ctrl_reg (
    .clk    (i_clk),
    .reset  (i_reset),
    .enable (load_en),
    .clear  (i_flush),
    .d      (ctrl_d),
    .q      (ctrl_q)
  );

  pipe_reg #(.WIDTH(DATA_W)) u_data_reg (
    .clk    (i_clk),
    .reset  (i_reset),
    .enable (load_en),
    .clear  (i_flush),
    .d      (data_d),
    .q      (data_q)
  );

  assign o_reg_write  = ctrl_q.reg_write;
  assign o_mem_read   = ctrl_q.mem_read;
  assign o_mem_write  = ctrl_q.mem_write;
  assign o_mem_to_reg = ctrl_q.mem_to_reg;
  assign o_alu_src    = ctrl_q.alu_src;
  assign o_reg_dst    = ctrl_q.reg_dst;
  assign o_mem_signed = ctrl_q.mem_signed;
  assign o_alu_op     = ctrl_q.alu_op;
  assign o_mem_width  = ctrl_q.mem_width;

`ifdef ID_EX_TRACE_EN
  // Counts only bubbles actually inserted; a flush blocked by halt is not one.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_bubble_count <= '0;
    end else if (i_flush && !i_halt && (o_bubble_count != 16'hFFFF)) begin
      o_bubble_count <= o_bubble_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Directed self-checking bench for id_ex_register (trace checks under ID_EX_TRACE_EN).
module tb_id_ex_register;

  logic        clk = 1'b0;
  logic        reset, halt, flush, valid;
  logic [31:0] rs_data, rt_data, imm_ext;
  logic [4:0]  rs_addr, rt_addr, rd_addr, shamt;
  logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, mem_signed;
  logic [2:0]  alu_op;
  logic [1:0]  mem_width;
  logic [31:0] o_rs_data, o_rt_data, o_imm_ext;
  logic [4:0]  o_rs_addr, o_rt_addr, o_rd_addr, o_shamt;
  logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst;
  logic        o_mem_signed, o_valid;
  logic [2:0]  o_alu_op;
  logic [1:0]  o_mem_width;
`ifdef ID_EX_TRACE_EN
  logic [31:0] pc_plus4, instr, o_pc_plus4, o_instr;
  logic [15:0] o_bubble_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_register dut (
    .i_clk(clk), .i_reset(reset), .i_halt(halt), .i_flush(flush), .i_valid(valid),
    .i_rs_data(rs_data), .i_rt_data(rt_data), .i_imm_ext(imm_ext),
    .i_rs_addr(rs_addr), .i_rt_addr(rt_addr), .i_rd_addr(rd_addr), .i_shamt(shamt),
    .i_reg_write(reg_write), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_mem_to_reg(mem_to_reg), .i_alu_src(alu_src), .i_reg_dst(reg_dst),
    .i_mem_signed(mem_signed), .i_alu_op(alu_op), .i_mem_width(mem_width),
`ifdef ID_EX_TRACE_EN
    .i_pc_plus4(pc_plus4), .i_instr(instr), .o_pc_plus4(o_pc_plus4), .o_instr(o_instr),
    .o_bubble_count(o_bubble_count),
`endif
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext),
    .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr), .o_rd_addr(o_rd_addr), .o_shamt(o_shamt),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_to_reg(o_mem_to_reg), .o_alu_src(o_alu_src), .o_reg_dst(o_reg_dst),
    .o_mem_signed(o_mem_signed), .o_alu_op(o_alu_op), .o_mem_width(o_mem_width),
    .o_valid(o_valid)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] rs, input logic [31:0] imm,
                               input logic v, input logic rw, input logic mw);
    rs_data   = rs;
    imm_ext   = imm;
    valid     = v;
    reg_write = rw;
    mem_write = mw;
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; flush = 1'b0; valid = 1'b0;
    rs_data = '0; rt_data = '0; imm_ext = '0;
    rs_addr = '0; rt_addr = '0; rd_addr = '0; shamt = '0;
    reg_write = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0;
    alu_src = 0; reg_dst = 0; mem_signed = 0; alu_op = '0; mem_width = '0;
`ifdef ID_EX_TRACE_EN
    pc_plus4 = '0; instr = '0;
`endif
    @(negedge clk);
    checkOutput("reset_valid", o_valid, 0);
    checkOutput("reset_rs", o_rs_data, 0);
    reset = 1'b0;

    // Normal load with one-cycle latency
    applyStimulus(32'h0000_1234, 32'hFFFF_FF80, 1'b1, 1'b1, 1'b0);
    rt_data = 32'h0000_5678; rd_addr = 5'd17; shamt = 5'd9;
    alu_op = 3'b101; mem_width = 2'b11; alu_src = 1'b1;
`ifdef ID_EX_TRACE_EN
    pc_plus4 = 32'h0040_0008; instr = 32'h2008_0005;
`endif
    #1;
    checkOutput("no_comb_path", o_rs_data, 0);
    @(negedge clk);
    checkOutput("load_rs", o_rs_data, 32'h0000_1234);
    checkOutput("load_rt", o_rt_data, 32'h0000_5678);
    checkOutput("load_imm", o_imm_ext, 32'hFFFF_FF80);
    checkOutput("load_rw", o_reg_write, 1);
    checkOutput("load_valid", o_valid, 1);
    checkOutput("load_rd", o_rd_addr, 17);
    checkOutput("load_shamt", o_shamt, 9);
    checkOutput("load_aluop", o_alu_op, 3'b101);
    checkOutput("load_memw", o_mem_width, 2'b11);
    checkOutput("load_alusrc", o_alu_src, 1);
`ifdef ID_EX_TRACE_EN
    checkOutput("load_pc", o_pc_plus4, 32'h0040_0008);
    checkOutput("load_instr", o_instr, 32'h2008_0005);
`endif

    // Asynchronous reset mid-cycle with nonzero inputs
    mem_write = 1'b1; rs_addr = 5'd3; rt_addr = 5'd4;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_rs", o_rs_data, 0);
    checkOutput("async_rst_imm", o_imm_ext, 0);
    checkOutput("async_rst_rw", o_reg_write, 0);
    checkOutput("async_rst_valid", o_valid, 0);
    @(negedge clk);
    reset = 1'b0;

    // First edge after reset loads normally, then a flush inserts a bubble
    applyStimulus(32'h0BAD_F00D, 32'h0000_0044, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("pre_flush_mw", o_mem_write, 1);
    checkOutput("pre_flush_imm", o_imm_ext, 32'h0000_0044);
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_mw", o_mem_write, 0);
    checkOutput("flush_valid", o_valid, 0);
    checkOutput("flush_imm", o_imm_ext, 0);
    checkOutput("flush_rs", o_rs_data, 0);
    checkOutput("flush_rd", o_rd_addr, 0);
    checkOutput("flush_aluop", o_alu_op, 0);
`ifdef ID_EX_TRACE_EN
    checkOutput("flush_instr", o_instr, 0);
    checkOutput("flush_count", o_bubble_count, 1);
`endif
    flush = 1'b0;

    // Halt beats flush; the dropped flush does not reappear afterwards
    applyStimulus(32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("halt_load_rs", o_rs_data, 32'hDEAD_BEEF);
    halt = 1'b1; flush = 1'b1;
    rs_data = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("halt_rs", o_rs_data, 32'hDEAD_BEEF);
      checkOutput("halt_valid", o_valid, 1);
      checkOutput("halt_rw", o_reg_write, 1);
    end
`ifdef ID_EX_TRACE_EN
    checkOutput("halt_count", o_bubble_count, 1);
`endif
    halt = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("post_halt_rs", o_rs_data, 32'h1111_1111);
    checkOutput("post_halt_valid", o_valid, 1);

    // Invalid entry: data passes, control forced off
    applyStimulus(32'hAAAA_5555, 32'h0000_7FFF, 1'b0, 1'b1, 1'b1);
    mem_read = 1'b1; mem_signed = 1'b1;
    @(negedge clk);
    checkOutput("inv_rs", o_rs_data, 32'hAAAA_5555);
    checkOutput("inv_imm", o_imm_ext, 32'h0000_7FFF);
    checkOutput("inv_rw", o_reg_write, 0);
    checkOutput("inv_mw", o_mem_write, 0);
    checkOutput("inv_mr", o_mem_read, 0);
    checkOutput("inv_signed", o_mem_signed, 0);
    checkOutput("inv_aluop", o_alu_op, 0);
    checkOutput("inv_valid", o_valid, 0);

    // Reset asserted during halt clears everything; no halt state survives
    applyStimulus(32'h7777_0001, 32'h0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("pre_rst_rs", o_rs_data, 32'h7777_0001);
    halt = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("halt_rst_rs", o_rs_data, 0);
    checkOutput("halt_rst_valid", o_valid, 0);
    @(negedge clk);
    reset = 1'b0; halt = 1'b0;
    @(negedge clk);
    checkOutput("after_rst_rs", o_rs_data, 32'h7777_0001);
    checkOutput("after_rst_valid", o_valid, 1);

`ifdef ID_EX_TRACE_EN
    checkOutput("rst_count", o_bubble_count, 0);
    flush = 1'b1;
    repeat (65537) @(negedge clk);
    checkOutput("sat_count", o_bubble_count, 16'hFFFF);
    flush = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register of the MIPS datapath. It captures the decode-stage outputs at each clock edge and presents them to the execute stage one cycle later: the register-file read data, the sign- or zero-extended immediate, register addresses and control bits. It supports a hold (pipeline halt) and a flush (bubble insertion for load-use hazards and taken branches), and marks every entry with a valid bit.

## Interface
Parameters:
- DATA_SIZE, 32, width of register data and extended immediate
- REG_ADDR_SIZE, 5, register address width
- ALU_OP_SIZE, 3, ALU operation code width

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_halt  in  1  freeze register contents (debug unit or global stall)
- i_flush  in  1  load a bubble on this edge
- i_valid  in  1  decode stage holds a real instruction
- i_rs_data, i_rt_data  in  DATA_SIZE  register-file read data
- i_imm_ext  in  DATA_SIZE  extended immediate from the decode-stage extender
- i_rs_addr, i_rt_addr, i_rd_addr  in  REG_ADDR_SIZE  register addresses, used for forwarding and destination selection
- i_shamt  in  5  shift amount
- i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_alu_src, i_reg_dst, i_mem_signed  in  1 each  control bits
- i_alu_op  in  ALU_OP_SIZE  ALU operation code
- i_mem_width  in  2  memory access width: 00 byte, 01 half, 11 word
- o_*  out  same widths  registered copies of every i_* data/control input listed above, including o_valid

## Operation
- Priority on each rising edge: i_reset > i_halt > i_flush > normal load.
- Normal load: every o_* output takes the value of its i_* input.
- Halt: all outputs hold their values. A flush that arrives during a halt is dropped; the unit that raised it must reassert it after the halt ends.
- Flush: o_valid and all control outputs (o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst, o_mem_signed, o_alu_op, o_mem_width) go to 0. Data and address outputs go to 0. The result is a NOP that has no architectural side effect.
- i_valid = 0 with no flush: the entry loads normally. All control bits are still forced to 0, so an invalid entry never writes registers or memory.
- There is no arithmetic in this block. Widths pass straight through, with no truncation or extension.

## Timing
- Latency is exactly 1 cycle from input to output.
- No combinational path from any input to any output.
- Reset is asynchronous. On assertion, every output goes to 0 immediately, including o_valid = 0.
- Reset deassertion is synchronous to i_clk upstream. The first edge after deassertion performs a normal load.
- Reset asserted mid-halt or mid-flush clears everything. No halt or flush state is retained.
- Halt and flush asserted together: halt wins and the outputs hold.

## Configuration
- ID_EX_TRACE_EN defined: adds the ports i_pc_plus4 and i_instr (in, DATA_SIZE) and o_pc_plus4 and o_instr (out, DATA_SIZE). These follow the same load, halt and flush rules; on flush, o_instr = 0 (NOP). The build also adds o_bubble_count (out, 16), which increments on every flush edge that is not blocked by halt, saturates at 0xFFFF, and resets to 0.
- ID_EX_TRACE_EN undefined: none of these ports or registers exist.

## Structure
- Shared package pipeline_pkg holds:
  - control field widths
  - mem_width encodings (MEM_BYTE, MEM_HALF, MEM_WORD)
  - ALU op constants
  - a packed ex_ctrl_t struct grouping the control bits, so the flush clears a single struct
- One generic sub-module, pipe_reg: a parameterised-width register with asynchronous reset, enable (hold) and synchronous clear (flush). It is instantiated once for the control struct and once for the data fields; the IF/ID and EX/MEM stages reuse it.

## Test plan
- Reset: assert i_reset mid-cycle with all inputs nonzero -> all outputs 0 before the next edge, o_valid = 0.
- Load: i_rs_data = 0x0000_1234, i_imm_ext = 0xFFFF_FF80, i_reg_write = 1, i_valid = 1 -> exactly one edge later, outputs equal these values.
- Flush: i_mem_write = 1, i_valid = 1, i_flush = 1 -> o_mem_write = 0, o_valid = 0, o_imm_ext = 0. With ID_EX_TRACE_EN defined, o_bubble_count increments by 1.
- Halt with flush: load 0xDEAD_BEEF, then hold i_halt = 1 and i_flush = 1 for 3 cycles -> o_rs_data stays 0xDEAD_BEEF and o_valid stays 1 throughout.
- Invalid entry: i_valid = 0, i_reg_write = 1 -> o_reg_write = 0 while data passes through.
- Counter saturation (ID_EX_TRACE_EN defined): 65 537 consecutive flushes -> o_bubble_count = 0xFFFF.
